pdecoder_seq: RTL and testbench

- Sequential inverse of the 8-to-3 priority encoder: accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot select line on an 8-bit output.
- Each select is held for a fixed number of cycles, followed by an all-zero guard gap.
- Sits downstream of the encoder, or of any code source, and drives select/strobe lines (LED banks, mux selects, interrupt acknowledges).

---
 rtl/pdecoder_pkg.sv | 17 +
 rtl/pdecoder_pending.sv | 24 ++
 rtl/pdecoder_seq.sv | 134 +++++++++++++
 tb/tb_pdecoder_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pdecoder_pkg.sv
// Shared types and helpers for the pdecoder_seq code-to-select sequencer.
package pdecoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Wide enough for the 255-cycle maximum of either timer.
  localparam int CNT_W = 8;

  function automatic logic [7:0] onehot8(input logic [2:0] c);
    return 8'b0000_0001 << c;
  endfunction

endpackage

// File: rtl/pdecoder_pending.sv
// One-entry code holding register with valid flag; used when PDECODER_QUEUE_EN is defined.
module pdecoder_pending (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic       pend_valid,
  output logic [2:0] pend_code
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_code  <= 3'd0;
    end else if (push) begin
      pend_valid <= 1'b1;
      pend_code  <= din;
    end else if (pop) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pdecoder_seq.sv
// Sequential 3-to-8 decoder: holds each accepted one-hot select, then a zero guard gap.
// Build option PDECODER_QUEUE_EN adds a one-entry pending slot so codes chain without an IDLE cycle.
//
// state | meaning
// IDLE  | waiting for a code, sel all-zero
// HOLD  | one-hot select driven, hold timer running
// GAP   | sel all-zero guard, gap timer running
module pdecoder_seq
  import pdecoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] sel,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sel_q, sel_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             at_end;
  logic             chain_ok;
  logic [2:0]       chain_code;

  assign xfer = valid & ready;

`ifdef PDECODER_QUEUE_EN
  logic       pend_valid;
  logic [2:0] pend_code;
  logic       pend_push;
  logic       pend_pop;

  assign ready      = !pend_valid;
  // Pending drains first; with it empty, a code arriving on the final cycle loads directly.
  assign chain_ok   = pend_valid | xfer;
  assign chain_code = pend_valid ? pend_code : code;
  assign pend_pop   = at_end & pend_valid;
  assign pend_push  = xfer & (state_q != IDLE) & !at_end;

  pdecoder_pending u_pending (
    .clk        (clk),
    .rst        (rst),
    .push       (pend_push),
    .pop        (pend_pop),
    .din        (code),
    .pend_valid (pend_valid),
    .pend_code  (pend_code)
  );
`else
  assign ready      = (state_q == IDLE);
  assign chain_ok   = 1'b0;
  assign chain_code = 3'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    at_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          sel_d   = onehot8(code);
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          sel_d  = '0;
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            at_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) at_end = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (at_end) begin
      if (chain_ok) begin
        sel_d   = onehot8(chain_code);
        cnt_d   = HOLD_LD;
        state_d = HOLD;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pdecoder_seq.sv
// Randomized bench for pdecoder_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) against a job-schedule model.
module tb_pdecoder_seq;

  localparam int NI   = 2;
  localparam int NJ   = 4;
  localparam int NCYC = 2200;

  int hc [NI] = '{4, 1};
  int gc [NI] = '{1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code_t  [NI];
  logic       valid_t [NI];
  logic       ready_t [NI];
  logic [7:0] sel_t   [NI];
  logic       busy_t  [NI];
  logic       done_t  [NI];

  always #5 clk = ~clk;

  pdecoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .code(code_t[0]), .valid(valid_t[0]),
    .ready(ready_t[0]), .sel(sel_t[0]), .busy(busy_t[0]), .done(done_t[0])
  );

  pdecoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .code(code_t[1]), .valid(valid_t[1]),
    .ready(ready_t[1]), .sel(sel_t[1]), .busy(busy_t[1]), .done(done_t[1])
  );

  // Model: each accepted code is a job with an accept cycle and a start cycle.
  int         j_acc [NI][NJ];
  int         j_st  [NI][NJ];
  logic [2:0] j_cd  [NI][NJ];
  bit         j_v   [NI][NJ];
  int         j_wr  [NI];
  logic [2:0] seqc  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_sel(int i, int c);
    logic [7:0] r = '0;
    for (int k = 0; k < NJ; k++)
      if (j_v[i][k] && c >= j_st[i][k] && c < j_st[i][k] + hc[i])
        r = 8'd1 << j_cd[i][k];
    return r;
  endfunction

  function automatic logic m_done(int i, int c);
    for (int k = 0; k < NJ; k++)
      if (j_v[i][k] && c == j_st[i][k] + hc[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(int i, int c);
    for (int k = 0; k < NJ; k++)
      if (j_v[i][k] && c >= j_st[i][k] && c < j_st[i][k] + hc[i] + gc[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready(int i, int c);
    for (int k = 0; k < NJ; k++) begin
`ifdef PDECODER_QUEUE_EN
      if (j_v[i][k] && j_acc[i][k] < c && j_st[i][k] > c) return 1'b0;
`else
      if (j_v[i][k] && c < j_st[i][k] + hc[i] + gc[i]) return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic int m_end(int i);
    int e = 0;
    for (int k = 0; k < NJ; k++)
      if (j_v[i][k] && j_st[i][k] + hc[i] + gc[i] > e) e = j_st[i][k] + hc[i] + gc[i];
    return e;
  endfunction

  initial begin
    logic       v;
    logic [2:0] cd;
    int         p;
    int         st;
    for (int i = 0; i < NI; i++) begin
      valid_t[i] = 1'b0;
      code_t[i]  = 3'd0;
      j_wr[i]    = 0;
      seqc[i]    = 3'd0;
      for (int k = 0; k < NJ; k++) j_v[i][k] = 1'b0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("sel%0d c%0d", i, c),   32'(sel_t[i]),   32'(m_sel(i, c)));
          chk($sformatf("done%0d c%0d", i, c),  32'(done_t[i]),  32'(m_done(i, c)));
          chk($sformatf("busy%0d c%0d", i, c),  32'(busy_t[i]),  32'(m_busy(i, c)));
          chk($sformatf("ready%0d c%0d", i, c), 32'(ready_t[i]), 32'(m_ready(i, c)));
        end
      end
      rst = (c < 3) || (c == 73) || (c >= 100 && $urandom_range(0, 199) == 0);
      p = ((c / 300) % 3 == 0) ? 20 : (((c / 300) % 3 == 1) ? 60 : 100);
      for (int i = 0; i < NI; i++) begin
        if (c == 3) begin
          v = 1'b1; cd = 3'd5;
        end else if (c >= 20 && c <= 60) begin
          v = 1'b1; cd = seqc[i];
        end else if (c == 71) begin
          v = 1'b1; cd = 3'd7;
        end else if (c >= 100) begin
          v  = ($urandom_range(0, 99) < p);
          cd = 3'($urandom_range(0, 7));
        end else begin
          v = 1'b0; cd = 3'($urandom_range(0, 7));
        end
        if (!rst && v && m_ready(i, c)) begin
`ifdef PDECODER_QUEUE_EN
          st = (m_end(i) > c + 1) ? m_end(i) : c + 1;
`else
          st = c + 1;
`endif
          j_acc[i][j_wr[i]] = c;
          j_st[i][j_wr[i]]  = st;
          j_cd[i][j_wr[i]]  = cd;
          j_v[i][j_wr[i]]   = 1'b1;
          j_wr[i]           = (j_wr[i] + 1) % NJ;
          if (c >= 20 && c <= 60) seqc[i] = seqc[i] + 3'd1;
        end
        if (rst)
          for (int k = 0; k < NJ; k++) j_v[i][k] = 1'b0;
        valid_t[i] = v;
        code_t[i]  = cd;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
